// File: rtl/fifo_ctrl.sv
// fifo_ctrl: first-word-fall-through stream controller around a 1-cycle-latency register-array memory.
// Define FIFO_CTRL_ALMOST_FULL_EN to build the registered almost_full flag; otherwise it is tied low.
module fifo_ctrl #(
  parameter int WIDTH     = 8,
  parameter int ADDR_W    = 3,
  parameter int AF_THRESH = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [WIDTH-1:0]  m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [WIDTH-1:0]  mem_wr_data,
  output logic              mem_rd_en,
  output logic [ADDR_W:0]   mem_rd_addr,
  input  logic [WIDTH-1:0]  mem_rd_data,
  output logic [ADDR_W+1:0] fill_level,
  output logic              almost_full
);

  localparam int PW = ADDR_W + 1;
  localparam int FW = ADDR_W + 2;

  // A threshold outside 1..capacity would make almost_full meaningless.
  if (AF_THRESH < 1 || AF_THRESH > (2**ADDR_W) + 2) begin : g_af_thresh_check
    $error("fifo_ctrl: AF_THRESH out of range");
  end

  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [1:0]       out_cnt_q, out_cnt_d;
  logic             infl_q, infl_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;

  logic [PW-1:0] mem_cnt;
  logic          mem_empty;
  logic          mem_full;
  logic          wr_fire;
  logic          pop;
  logic          push;
  logic          rd_issue;
  logic [2:0]    occupancy;

  assign mem_cnt   = wptr_q - rptr_q;
  assign mem_empty = (wptr_q == rptr_q);
  assign mem_full  = (wptr_q[ADDR_W] != rptr_q[ADDR_W]) &&
                     (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]);

  assign s_ready = !rst && !mem_full;
  assign wr_fire = s_valid && s_ready;

  assign m_valid = !rst && (out_cnt_q != 2'd0);
  assign m_data  = head_q;
  assign pop     = m_valid && m_ready;

  // Read data from a read issued just before a reset must never land in the buffer.
  assign push      = infl_q && !rst;
  assign occupancy = {1'b0, out_cnt_q} + {2'b00, infl_q} - {2'b00, pop};
  assign rd_issue  = !rst && !mem_empty && (occupancy < 3'd2);

  assign mem_wr_en   = wr_fire;
  assign mem_wr_addr = wptr_q[ADDR_W-1:0];
  assign mem_wr_data = s_data;
  assign mem_rd_en   = rd_issue;
  assign mem_rd_addr = rptr_q;

  assign fill_level = rst ? '0 : (FW'(mem_cnt) + FW'(infl_q) + FW'(out_cnt_q));

  always_comb begin
    wptr_d    = wptr_q + PW'(wr_fire);
    rptr_d    = rptr_q + PW'(rd_issue);
    infl_d    = rd_issue;
    out_cnt_d = out_cnt_q + {1'b0, push} - {1'b0, pop};
    head_d    = head_q;
    tail_d    = tail_q;
    if (pop) begin
      head_d = tail_q;
    end
    // Arriving data goes to whichever slot is the tail once this cycle's pop is applied.
    if (push) begin
      if (out_cnt_q == 2'd0 || (out_cnt_q == 2'd1 && pop)) begin
        head_d = mem_rd_data;
      end else begin
        tail_d = mem_rd_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      out_cnt_q <= 2'd0;
      infl_q    <= 1'b0;
      head_q    <= '0;
      tail_q    <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      out_cnt_q <= out_cnt_d;
      infl_q    <= infl_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
    end
  end

`ifdef FIFO_CTRL_ALMOST_FULL_EN
  logic [PW-1:0] mem_cnt_d;
  logic [FW-1:0] fill_d;
  logic          af_q;

  assign mem_cnt_d = wptr_d - rptr_d;
  assign fill_d    = FW'(mem_cnt_d) + FW'(infl_d) + FW'(out_cnt_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      af_q <= 1'b0;
    end else begin
      af_q <= (fill_d >= FW'(AF_THRESH));
    end
  end

  assign almost_full = af_q && !rst;
`else
  assign almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: scenario tasks plus a negedge scoreboard monitor around fifo_ctrl and a register-array memory model.
// Honours FIFO_CTRL_ALMOST_FULL_EN to decide whether almost_full is expected to track the fill level.
module tb_fifo_ctrl;

  localparam int WIDTH     = 8;
  localparam int ADDR_W    = 3;
  localparam int AF_THRESH = 6;
  localparam int DEPTH     = 2**ADDR_W;
`ifdef FIFO_CTRL_ALMOST_FULL_EN
  localparam bit AF_EN = 1'b1;
`else
  localparam bit AF_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [WIDTH-1:0]  s_data = '0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [WIDTH-1:0]  m_data;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [WIDTH-1:0]  mem_wr_data;
  logic              mem_rd_en;
  logic [ADDR_W:0]   mem_rd_addr;
  logic [WIDTH-1:0]  memRdData = '0;
  logic [ADDR_W+1:0] fill_level;
  logic              almost_full;

  logic [WIDTH-1:0] memArr [DEPTH];
  logic [WIDTH-1:0] expQ [$];
  logic [WIDTH-1:0] expWord;
  int checks = 0;
  int failures = 0;
  int modelFill = 0;
  int popCount = 0;
  bit monEn = 1'b0;

  fifo_ctrl #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .AF_THRESH(AF_THRESH)) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(memRdData),
    .fill_level(fill_level), .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < DEPTH; i++) memArr[i] = '0;
  end

  // Memory model: synchronous write, registered read port with one cycle of latency.
  always @(posedge clk) begin
    if (mem_wr_en) memArr[mem_wr_addr] <= mem_wr_data;
    if (mem_rd_en) memRdData <= memArr[mem_rd_addr[ADDR_W-1:0]];
  end

  // Scoreboard: pushes on accept, pops and compares on every consumer handshake, tracks fill level.
  always @(negedge clk) begin
    if (monEn) begin
      if (rst) begin
        checks++;
        if (m_valid !== 1'b0 || fill_level !== '0 || almost_full !== 1'b0 || s_ready !== 1'b0) begin
          failures++;
          $display("[TB] FAIL reset_outputs m_valid=%b fill=%0d af=%b s_ready=%b required 0/0/0/0",
                   m_valid, fill_level, almost_full, s_ready);
        end
        expQ.delete();
        modelFill = 0;
      end else begin
        checks++;
        if (fill_level !== 5'(modelFill)) begin
          failures++;
          $display("[TB] FAIL fill_level got=%0d required=%0d at %0t", fill_level, modelFill, $time);
        end
        checks++;
        if (almost_full !== (AF_EN && (modelFill >= AF_THRESH))) begin
          failures++;
          $display("[TB] FAIL almost_full got=%b required=%b fill=%0d", almost_full,
                   (AF_EN && (modelFill >= AF_THRESH)), modelFill);
        end
        if (s_valid && s_ready) begin
          expQ.push_back(s_data);
          modelFill++;
        end
        if (m_valid && m_ready) begin
          checks++;
          popCount++;
          modelFill--;
          if (expQ.size() == 0) begin
            failures++;
            $display("[TB] FAIL pop_unexpected got=%h required=no word", m_data);
          end else begin
            expWord = expQ.pop_front();
            if (m_data !== expWord) begin
              failures++;
              $display("[TB] FAIL pop_data got=%h required=%h at %0t", m_data, expWord, $time);
            end
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int maxCyc);
    int n;
    n = 0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    while ((expQ.size() != 0 || m_valid) && n < maxCyc) begin
      tick();
      n++;
    end
    m_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_valid = 1'b1;
    s_data = 8'h55;
    m_ready = 1'b1;
    monEn = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (mem_wr_en !== 1'b0 || mem_rd_en !== 1'b0) begin
        failures++;
        $display("[TB] FAIL reset_strobes wr_en=%b rd_en=%b required 0/0", mem_wr_en, mem_rd_en);
      end
      tick();
    end
    rst = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL after_reset s_ready=%b m_valid=%b required 1/0", s_ready, m_valid);
    end
    tick();
  endtask

  task automatic test_single_latency();
    int startPops;
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data = 8'hA5;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1 || mem_wr_en !== 1'b1 || mem_wr_addr !== 3'd0) begin
      failures++;
      $display("[TB] FAIL accept_a5 s_ready=%b wr_en=%b addr=%0d required 1/1/0", s_ready, mem_wr_en, mem_wr_addr);
    end
    tick();
    s_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (m_valid !== (k == 3)) begin
        failures++;
        $display("[TB] FAIL latency_m_valid cycle=N+%0d got=%b required=%b", k, m_valid, (k == 3));
      end
      if (k == 1) begin
        checks++;
        if (mem_rd_en !== 1'b1 || mem_rd_addr !== 4'd0) begin
          failures++;
          $display("[TB] FAIL latency_rd_issue rd_en=%b addr=%0d required 1/0", mem_rd_en, mem_rd_addr);
        end
      end
      if (k == 3) begin
        checks++;
        if (m_data !== 8'hA5 || fill_level !== 5'd1) begin
          failures++;
          $display("[TB] FAIL latency_head m_data=%h fill=%0d required a5/1", m_data, fill_level);
        end
      end
      tick();
    end
    startPops = popCount;
    drain(10);
    checks++;
    if (popCount !== startPops + 1) begin
      failures++;
      $display("[TB] FAIL single_drain pops=%0d required=%0d", popCount - startPops, 1);
    end
  endtask

  task automatic test_full_drain();
    int waitCyc;
    bit got;
    int startPops;
    m_ready = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      s_valid = 1'b1;
      s_data = WIDTH'(i);
      got = 1'b0;
      waitCyc = 0;
      while (!got && waitCyc < 20) begin
        @(negedge clk);
        got = s_ready;
        tick();
        waitCyc++;
      end
      checks++;
      if (!got) begin
        failures++;
        $display("[TB] FAIL full_fill_timeout word=%0d s_ready=%b required 1", i, s_ready);
      end
    end
    s_valid = 1'b1;
    s_data = 8'hEE;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (s_ready !== 1'b0 || fill_level !== 5'd10) begin
        failures++;
        $display("[TB] FAIL full_hold s_ready=%b fill=%0d required 0/10", s_ready, fill_level);
      end
      tick();
    end
    startPops = popCount;
    drain(40);
    checks++;
    if (popCount !== startPops + 10 || expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL full_drain pops=%0d left=%0d required 10/0", popCount - startPops, expQ.size());
    end
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || fill_level !== 5'd0) begin
      failures++;
      $display("[TB] FAIL drained_empty m_valid=%b fill=%0d required 0/0", m_valid, fill_level);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int gaps;
    int startPops;
    gaps = 0;
    startPops = popCount;
    m_ready = 1'b1;
    for (int c = 0; c < 69; c++) begin
      s_valid = (c < 64);
      s_data = WIDTH'(c + 100);
      @(negedge clk);
      if (c < 64 && s_ready !== 1'b1) gaps++;
      if (m_valid !== (c >= 3 && c <= 66)) gaps++;
      tick();
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
    checks++;
    if (gaps != 0 || popCount !== startPops + 64) begin
      failures++;
      $display("[TB] FAIL stream_throughput gaps=%0d pops=%0d required 0/64", gaps, popCount - startPops);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 2000; c++) begin
      s_valid = 1'($urandom_range(0, 1));
      m_ready = 1'($urandom_range(0, 1));
      s_data = WIDTH'($urandom);
      tick();
    end
    drain(40);
    checks++;
    if (expQ.size() != 0 || fill_level !== 5'd0) begin
      failures++;
      $display("[TB] FAIL random_drain left=%0d fill=%0d required 0/0", expQ.size(), fill_level);
    end
  endtask

  task automatic test_reset_midflight();
    int stuck;
    int startPops;
    m_ready = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_data = WIDTH'(8'hC0 + i);
      tick();
    end
    s_valid = 1'b0;
    tick();
    tick();
    m_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_rd_en !== 1'b1 || fill_level !== 5'd5) begin
      failures++;
      $display("[TB] FAIL midflight_setup rd_en=%b fill=%0d required 1/5", mem_rd_en, fill_level);
    end
    tick();
    m_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || fill_level !== 5'd0 || s_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midflight_reset m_valid=%b fill=%0d s_ready=%b required 0/0/1", m_valid, fill_level, s_ready);
    end
    tick();
    stuck = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (m_valid !== 1'b0) stuck++;
      tick();
    end
    checks++;
    if (stuck != 0) begin
      failures++;
      $display("[TB] FAIL stale_data_visible cycles=%0d required=0", stuck);
    end
    startPops = popCount;
    s_valid = 1'b1;
    s_data = 8'h3C;
    tick();
    drain(10);
    checks++;
    if (popCount !== startPops + 1) begin
      failures++;
      $display("[TB] FAIL post_reset_word pops=%0d required=1", popCount - startPops);
    end
  endtask

  task automatic test_almost_full();
    m_ready = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      s_valid = 1'b1;
      s_data = WIDTH'(8'h60 + k);
      tick();
      s_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (almost_full !== (AF_EN && (k >= AF_THRESH))) begin
        failures++;
        $display("[TB] FAIL almost_full_step k=%0d got=%b required=%b", k, almost_full, (AF_EN && (k >= AF_THRESH)));
      end
      tick();
    end
    drain(30);
    checks++;
    if (expQ.size() != 0 || almost_full !== 1'b0) begin
      failures++;
      $display("[TB] FAIL almost_full_drain left=%0d af=%b required 0/0", expQ.size(), almost_full);
    end
  endtask

  initial begin
    test_reset();
    test_single_latency();
    test_full_drain();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    test_almost_full();
    monEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Single-clock FIFO controller that sequences the team's dual-port register-array memory, the one with a registered read port and 1-cycle read latency. It owns the write and read pointers, issues the memory write and read enables, and adds a 2-entry prefetch output buffer. The result is a first-word-fall-through valid/ready stream with full throughput. It sits between a MAC-side producer and consumer wherever both run on the same clock.

## Interface
- `WIDTH`, 8, data width in bits.
- `ADDR_W`, 3, memory address width; memory depth `2**ADDR_W`.
- `AF_THRESH`, 6, almost-full threshold on `fill_level`. Used only with `FIFO_CTRL_ALMOST_FULL_EN`.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock. All logic is on its rising edge.
- `rst` in 1: **one clock; reset is synchronous and active-high.**
- `s_data` in WIDTH: write data.
- `s_valid` in 1: write request.
- `s_ready` out 1: controller can accept a word.
- `m_data` out WIDTH: head-of-FIFO data.
- `m_valid` out 1: `m_data` is valid.
- `m_ready` in 1: consumer accepts `m_data`.
- `mem_wr_en` out 1: memory write strobe.
- `mem_wr_addr` out ADDR_W: memory write address.
- `mem_wr_data` out WIDTH: memory write data, equal to `s_data`.
- `mem_rd_en` out 1: memory read strobe.
- `mem_rd_addr` out ADDR_W+1: read pointer including the wrap bit. The memory uses the low ADDR_W bits.
- `mem_rd_data` in WIDTH: memory read data, valid the cycle after `mem_rd_en`.
- `fill_level` out ADDR_W+2: total words held.
- `almost_full` out 1: `fill_level >= AF_THRESH`.

## Operation
- Pointers:
  - `wptr` and `rptr` are each ADDR_W+1 bits and wrap modulo `2**(ADDR_W+1)`.
  - `mem_cnt = wptr - rptr`, computed modulo, ADDR_W+1 bits.
  - Memory empty: `wptr == rptr`.
  - Memory full: MSBs differ and the low bits are equal.
- Write side:
  - `s_ready = !rst && !mem_full`.
  - On `s_valid && s_ready`: `mem_wr_en=1`, `mem_wr_addr=wptr[ADDR_W-1:0]`, and `wptr` increments.
  - A write is never dropped. `s_valid` while `!s_ready` has no effect.
- Read prefetch:
  - `out_cnt` is 0..2 and counts words in the 2-entry output buffer.
  - `infl` is 0..1 and counts reads issued whose data has not yet arrived.
  - `pop = m_valid && m_ready`.
  - Issue `mem_rd_en=1` (with `mem_rd_addr=rptr`, then `rptr++`) when `!mem_empty && (out_cnt + infl - pop) < 2`.
  - The cycle after an issue, `mem_rd_data` is written into the buffer tail and `infl` clears.
- Output buffer:
  - 2-entry in-order queue.
  - `m_data` is the head entry; `m_valid = (out_cnt != 0)`.
  - Push and pop in the same cycle leave `out_cnt` unchanged, and the order is preserved.
- `fill_level = mem_cnt + infl + out_cnt`. Maximum is `2**ADDR_W + 2`.
- Reset:
  - Clears `wptr`, `rptr`, `out_cnt` and `infl`.
  - During and after reset: `m_valid=0`, `mem_wr_en=0`, `mem_rd_en=0`, `fill_level=0`, `almost_full=0`.
  - `s_ready=0` while `rst` is high and 1 in the first cycle after.
  - Reset mid-transfer discards all contents, including an in-flight read; its data is ignored.

## Timing
- Write-to-read latency: a word accepted in cycle N is written to memory at the end of N.
  - `mem_rd_en` is issued in N+1.
  - Data is captured in N+2.
  - `m_valid=1` in N+3.
- Throughput: with continuous `s_valid` and `m_ready`, one word per cycle sustained on both sides after the initial latency.
- Flags:
  - `s_ready` depends combinationally only on `rst` and the pointers. There is no combinational path from `m_ready`.
  - `m_valid` and `m_data` are registered.
  - `fill_level` is combinational from registers.
- Full boundary: when the memory holds `2**ADDR_W` words, `s_ready=0`. A read issued in cycle N frees a slot, so `s_ready=1` in N+1.
- Empty boundary: with `mem_empty` and `infl=0`, no read is issued. `m_valid` stays 1 until `out_cnt` reaches 0.
- Simultaneous write and read issue on the same address cannot occur, because a read issues only a cycle after the pointer update.

## Configuration
- `FIFO_CTRL_ALMOST_FULL_EN` defined:
  - `almost_full` is a register updated each cycle from the next-state `fill_level >= AF_THRESH`.
  - It is cleared by reset.
- `FIFO_CTRL_ALMOST_FULL_EN` undefined:
  - `almost_full` is tied to 0.
  - `AF_THRESH` is unused, and no comparator logic exists.

## Test plan
Defaults throughout (ADDR_W=3, capacity 8+2).
- Reset then single write `0xA5` with `m_ready=0` -> `m_valid=1` exactly 3 cycles after acceptance, `m_data=0xA5`, `fill_level=1`.
- Write `0x01..0x0A` with `m_ready=0` -> `s_ready` drops after the 10th accept, `fill_level=10`. Drain -> `0x01..0x0A` in order, then `m_valid=0` and `fill_level=0`.
- Continuous stream of 64 incrementing words, `s_valid=m_ready=1` -> one accept and one pop per cycle after cycle 3, no gaps, pointer wrap exercised, data is in order.
- Random `s_valid` and `m_ready` at 50% for 2000 cycles -> scoreboard matches. `fill_level` equals accepts minus pops every cycle.
- Assert `rst` for 1 cycle with 5 words held and a read in flight -> next cycle `m_valid=0` and `fill_level=0`. The stale `mem_rd_data` never appears on `m_data`.
- With the macro defined and `AF_THRESH=6`: fill to 5 -> `almost_full=0`; the 6th accept -> `almost_full=1` the next cycle. Without the macro, `almost_full=0` throughout.
